pipelined_slice_adder: RTL and testbench
========================================

// Module: pipelined_slice_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit adder built from a generate loop of SLICE-bit adders.
//  One register stage per slice; the carry ripples between stages.
//  Accepts one operand pair per cycle under a valid/ready handshake with output backpressure.
//  Successor to the combinational bank of two-bit adders; used where wide adds must meet timing.
// PARAMETERS
//  WIDTH   8  operand/sum width in bits; must be a multiple of SLICE (elaboration error otherwise)
//  SLICE   2  bits added per pipeline stage
//  STAGES  WIDTH/SLICE  localparam: pipeline depth and latency in cycles
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  in_valid     in   1           a/b/cin are valid this cycle
//  in_ready     out  1           block can accept this cycle
//  a            in   WIDTH       operand A
//  b            in   WIDTH       operand B
//  cin          in   1           carry into slice 0
//  out_valid    out  1           sum/cout/ovf/slice_carry are valid
//  out_ready    in   1           downstream accepts this cycle
//  sum          out  WIDTH       a+b+cin, modulo 2^WIDTH
//  cout         out  1           carry out of the MSB
//  ovf          out  1           signed (two's-complement) overflow
//  slice_carry  out  STAGES      carry out of each slice; bit i = slice i
// BEHAVIOUR
//  - Reset: async assert clears every stage valid bit and every data register; outputs read 0
//    (out_valid=0, sum=0, cout=0, ovf=0, slice_carry=0). in_ready=1 once reset is released.
//  - Advance: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0.
//    in_ready = adv; the transfer occurs on in_valid && in_ready.
//  - Stage k (0..STAGES-1): adds a/b bits [k*SLICE +: SLICE] and the carry registered by stage k-1
//    (cin for k=0). It registers its sum slice, its carry, and the not-yet-consumed upper operand bits.
//    Lower sum slices are carried forward (deskewed) so that every field of one result appears together.
//  - Latency: exactly STAGES cycles from acceptance to out_valid with no stall; each stall cycle adds one.
//    Throughput is 1 result per cycle while out_ready=1.
//  - Bubbles: a cycle with in_valid=0 and adv=1 inserts an invalid entry; data in bubbles is don't-care
//    but is not presented, because out_valid=0.
//  - Order: results leave in acceptance order; no drop or duplication under any out_ready pattern.
//  - Hold: while out_valid=1 && out_ready=0, all outputs stay stable.
//  - cout = carry of stage STAGES-1.
//    ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]); the operand MSBs travel with the data.
//  - Wrap-around: the sum is truncated to WIDTH bits; the carry is reported only via cout.
//  - Simultaneous accept + emit at the same edge is legal and required for full throughput.
//  - Reset mid-operation: all in-flight results are discarded; no out_valid pulse follows the release.
//  - SLICE==WIDTH degenerates to a single registered adder (STAGES=1, latency 1).
// TESTING (WIDTH=8, SLICE=2, latency 4)
//  1. Reset: hold rst_n=0 -> out_valid=0, sum=0x00, cout=0, ovf=0, slice_carry=4'b0000, in_ready=1 after release.
//  2. a=0x25, b=0x13, cin=0, out_ready=1 -> 4 cycles later: sum=0x38, cout=0, ovf=0, slice_carry=4'b0001.
//  3. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, slice_carry=4'b1111;
//     a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1, slice_carry=4'b0111.
//  4. a=0xFE, b=0x00, cin=1 -> sum=0xFF, cout=0, ovf=0; checks the cin path.
//  5. Stream 6 back-to-back pairs, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall,
//     outputs hold, all 6 results arrive correct and in order.
//  6. Accept 3 pairs, pulse rst_n=0 for 1 cycle -> out_valid stays 0 afterwards; next accepted pair
//     emerges after exactly 4 cycles.

Source files
------------

// File: rtl/pipelined_slice_adder.sv
// Pipelined WIDTH-bit adder: one register stage per SLICE-bit slice, carry ripples stage to
// stage, lower sum slices and carries are deskewed so a whole result emerges at once.
module pipelined_slice_adder #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         sum,
   output logic                     cout,
   output logic                     ovf,
   output logic [WIDTH/SLICE-1:0]   slice_carry
);

   localparam int STAGES = WIDTH / SLICE;

   if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_check
      $error("pipelined_slice_adder: WIDTH must be a non-zero multiple of SLICE");
   end

   logic adv;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic              v_in;
      logic              c_in;
      logic [WIDTH-1:0]  a_in;
      logic [WIDTH-1:0]  b_in;
      logic [WIDTH-1:0]  sum_in;
      logic [STAGES-1:0] carry_in;
      logic [SLICE:0]    slice_add;
      logic [WIDTH-1:0]  sum_nxt;
      logic [STAGES-1:0] carry_nxt;

      logic              valid_q;
      logic [WIDTH-1:0]  a_q;
      logic [WIDTH-1:0]  b_q;
      logic [WIDTH-1:0]  sum_q;
      logic [STAGES-1:0] carry_q;

      if (k == 0) begin : g_head
         assign v_in     = in_valid;
         assign a_in     = a;
         assign b_in     = b;
         assign sum_in   = '0;
         assign carry_in = '0;
         assign c_in     = cin;
      end else begin : g_body
         assign v_in     = g_stage[k-1].valid_q;
         assign a_in     = g_stage[k-1].a_q;
         assign b_in     = g_stage[k-1].b_q;
         assign sum_in   = g_stage[k-1].sum_q;
         assign carry_in = g_stage[k-1].carry_q;
         assign c_in     = g_stage[k-1].carry_q[k-1];
      end

      assign slice_add = {1'b0, a_in[k*SLICE +: SLICE]} + {1'b0, b_in[k*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, c_in};

      // Slices below k pass through unchanged; only this stage's slice and carry are new.
      always_comb begin
         sum_nxt                   = sum_in;
         sum_nxt[k*SLICE +: SLICE] = slice_add[SLICE-1:0];
         carry_nxt                 = carry_in;
         carry_nxt[k]              = slice_add[SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
         end else if (adv) begin
            valid_q <= v_in;
            a_q     <= a_in;
            b_q     <= b_in;
            sum_q   <= sum_nxt;
            carry_q <= carry_nxt;
         end
      end
   end

   assign out_valid   = g_stage[STAGES-1].valid_q;
   assign sum         = g_stage[STAGES-1].sum_q;
   assign slice_carry = g_stage[STAGES-1].carry_q;
   assign cout        = g_stage[STAGES-1].carry_q[STAGES-1];
   assign ovf         = (g_stage[STAGES-1].a_q[WIDTH-1] == g_stage[STAGES-1].b_q[WIDTH-1])
                     && (g_stage[STAGES-1].sum_q[WIDTH-1] != g_stage[STAGES-1].a_q[WIDTH-1]);

   // Only the operand MSBs are needed at the output; the rest of the last stage is dead.
   logic unused_ops;
   assign unused_ops = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};

endmodule

// File: tb/tb_pipelined_slice_adder.sv
// Self-checking bench for pipelined_slice_adder (WIDTH=8, SLICE=2, latency 4) against an
// arithmetic reference model and a FIFO scoreboard.
module tb_pipelined_slice_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;
   logic [3:0] slice_carry;

   int checks;
   int errors;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      logic [3:0] sc;
   } exp_t;

   pipelined_slice_adder #(
      .WIDTH(8),
      .SLICE(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum        (sum),
      .cout       (cout),
      .ovf        (ovf),
      .slice_carry(slice_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      exp_t r;
      int   full;
      int   sx;
      int   sy;
      int   ss;
      int   m;
      full   = int'(x) + int'(y) + int'(c);
      r.sum  = 8'(full);
      r.cout = (full >= 256);
      sx     = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
      sy     = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
      ss     = sx + sy + int'(c);
      r.ovf  = (ss > 127) || (ss < -128);
      for (int i = 0; i < 4; i++) begin
         m       = 1 << (2 * (i + 1));
         r.sc[i] = (((int'(x) % m) + (int'(y) % m) + int'(c)) >= m);
      end
      return r;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 8'h00;
      b         = 8'h00;
      cin       = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, sum, cout, ovf, slice_carry} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got out_valid=%b sum=%h cout=%b ovf=%b sc=%b, want all 0",
                  out_valid, sum, cout, ovf, slice_carry);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
   endtask

   // One transaction into an empty pipe; checks latency and every result field.
   task automatic test_single(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                              input string name);
      exp_t e;
      int   n;
      e = ref_add(ta, tb, tc);
      n = 0;
      @(negedge clk);
      a         = ta;
      b         = tb;
      cin       = tc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_in_ready: got %b, want 1", name, in_ready);
      end
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while ((out_valid !== 1'b1) && (n < 20));
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles, want 4", name, n);
      end
      checks++;
      if ({sum, cout, ovf, slice_carry} !== e) begin
         errors++;
         $display("FAIL %s_result: got sum=%h cout=%b ovf=%b sc=%b, want sum=%h cout=%b ovf=%b sc=%b",
                  name, sum, cout, ovf, slice_carry, e.sum, e.cout, e.ovf, e.sc);
      end
      @(negedge clk);
   endtask

   // Streams n random pairs; mode 0 stalls out_ready for cycles 6..8, mode 1 randomises both sides.
   task automatic test_stream(input int n, input bit rand_mode, input string name);
      exp_t       q[$];
      int         sent;
      int         got;
      int         cyc;
      logic [7:0] ca;
      logic [7:0] cb;
      logic       cc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      ca   = 8'($urandom);
      cb   = 8'($urandom);
      cc   = 1'($urandom);
      while ((got < n) && (cyc < 400)) begin
         @(negedge clk);
         cyc++;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
         else           out_ready = !((cyc >= 6) && (cyc <= 8));
         in_valid = (sent < n) && (rand_mode ? ($urandom_range(0, 4) != 0) : 1'b1);
         a   = ca;
         b   = cb;
         cin = cc;
         #1;
         if ((out_valid === 1'b1) && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s_stall_in_ready: cycle %0d got %b, want 0", name, cyc, in_ready);
            end
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL %s_spurious: cycle %0d out_valid=1 with nothing outstanding",
                        name, cyc);
            end else begin
               if ({sum, cout, ovf, slice_carry} !== q[0]) begin
                  errors++;
                  $display("FAIL %s_result%0d: got sum=%h cout=%b ovf=%b sc=%b, want sum=%h cout=%b ovf=%b sc=%b",
                           name, got, sum, cout, ovf, slice_carry,
                           q[0].sum, q[0].cout, q[0].ovf, q[0].sc);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  got++;
               end
            end
         end
         if (in_valid && (in_ready === 1'b1)) begin
            q.push_back(ref_add(ca, cb, cc));
            sent++;
            ca = 8'($urandom);
            cb = 8'($urandom);
            cc = 1'($urandom);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if ((got != n) || (q.size() != 0)) begin
         errors++;
         $display("FAIL %s_count: got %0d results (%0d pending), want %0d", name, got, q.size(), n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int bad;
      bad       = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a        = 8'($urandom);
         b        = 8'($urandom);
         cin      = 1'($urandom);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if ({out_valid, sum, cout, ovf, slice_carry} !== 15'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got out_valid=%b sum=%h cout=%b ovf=%b sc=%b, want all 0",
                  out_valid, sum, cout, ovf, slice_carry);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_flush: out_valid high on %0d cycles, want 0", bad);
      end
      test_single(8'h5A, 8'hC3, 1'b1, "after_reset");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single(8'h25, 8'h13, 1'b0, "basic");
      test_single(8'hFF, 8'h01, 1'b0, "wrap");
      test_single(8'h7F, 8'h01, 1'b0, "overflow");
      test_single(8'hFE, 8'h00, 1'b1, "cin");
      test_single(8'h80, 8'h80, 1'b1, "neg_overflow");
      test_stream(6, 1'b0, "back_to_back");
      test_stream(40, 1'b1, "random");
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
